timing_capture: RTL and testbench

TIMING_CAPTURE -- requirements
Module: timing_capture

---
 rtl/timing_pkg.sv | 12 +
 rtl/sync_rise_detect.sv | 27 ++
 rtl/timing_capture.sv | 109 ++++++++++
 tb/tb_timing_capture.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timing_pkg.sv
// Shared types and sizes for the feedback timing capture block.
package timing_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int RAM_WIDTH = 32;
    localparam int TCNT_W    = 16;

endpackage

// File: rtl/sync_rise_detect.sv
// Multi-flop synchronizer on an asynchronous level, plus a history flop
// that turns the synchronized level into a single-cycle rise pulse.
module sync_rise_detect #(
    parameter int STAGES = 2
) (
    input  logic io_clk,
    input  logic io_rst,
    input  logic io_in,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], io_in};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/timing_capture.sv
// Measures cycles from a trigger strobe to the next rising edge of an
// asynchronous feedback line, with a bounded window and timeout count.
module timing_capture
    import timing_pkg::*;
#(
    parameter int              _RAM_WIDTH   = RAM_WIDTH,
    parameter int              _SYNC_STAGES = 2,
    parameter longint unsigned _TIMEOUT     = 32'd1_000_000
) (
    input  logic                  io_clk,
    input  logic                  io_rst,
    input  logic                  io_trigIn,
    input  logic                  io_fbIn,
    output logic [_RAM_WIDTH-1:0] io_timingOut,
    output logic                  io_fbCatchOut,
    output logic                  io_timeout,
    output logic                  io_busy,
    output logic [TCNT_W-1:0]     io_timeoutCnt
);

    localparam logic [_RAM_WIDTH-1:0] TIMEOUT_V =
        _RAM_WIDTH'(_TIMEOUT);

    state_t                  state_q;
    state_t                  state_d;
    logic [_RAM_WIDTH-1:0]   cnt_q;
    logic [_RAM_WIDTH-1:0]   cnt_d;
    logic [_RAM_WIDTH-1:0]   cnt_inc;
    logic [_RAM_WIDTH-1:0]   timing_q;
    logic [_RAM_WIDTH-1:0]   timing_d;
    logic [TCNT_W-1:0]       tcnt_q;
    logic [TCNT_W-1:0]       tcnt_d;
    logic                    catch_q;
    logic                    catch_d;
    logic                    timeout_q;
    logic                    timeout_d;
    logic                    busy_q;
    logic                    rise;

    sync_rise_detect #(
        .STAGES (_SYNC_STAGES)
    ) u_sync (
        .io_clk (io_clk),
        .io_rst (io_rst),
        .io_in  (io_fbIn),
        .rise   (rise)
    );

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timing_d  = timing_q;
        tcnt_d    = tcnt_q;
        catch_d   = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (io_trigIn) begin
                    cnt_d   = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                cnt_d = cnt_inc;
                // A capture on the final window edge takes priority
                if (rise) begin
                    timing_d = cnt_inc;
                    catch_d  = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_inc == TIMEOUT_V) begin
                    timeout_d = 1'b1;
                    if (tcnt_q != '1)
                        tcnt_d = tcnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timing_q  <= '0;
            tcnt_q    <= '0;
            catch_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timing_q  <= timing_d;
            tcnt_q    <= tcnt_d;
            catch_q   <= catch_d;
            timeout_q <= timeout_d;
            busy_q    <= (state_d == COUNT);
        end
    end

    assign io_timingOut  = timing_q;
    assign io_fbCatchOut = catch_q;
    assign io_timeout    = timeout_q;
    assign io_busy       = busy_q;
    assign io_timeoutCnt = tcnt_q;

endmodule

// File: tb/tb_timing_capture.sv
// Randomized bench for timing_capture with a window-level reference
// model feeding a strobe scoreboard.
module tb_timing_capture;

    localparam int W  = 32;
    localparam int S  = 2;
    localparam int TO = 16;

    logic          io_clk = 1'b0;
    logic          io_rst = 1'b1;
    logic          io_trigIn = 1'b0;
    logic          io_fbIn = 1'b0;
    logic [W-1:0]  io_timingOut;
    logic          io_fbCatchOut;
    logic          io_timeout;
    logic          io_busy;
    logic [15:0]   io_timeoutCnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit is_catch;
        int timing;
        int tcnt;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    bit   smp[$];
    bit   m_busy;
    int   m_t0;
    int   m_timing;
    int   m_tcnt;

    always #5 io_clk = ~io_clk;

    timing_capture #(
        ._RAM_WIDTH   (W),
        ._SYNC_STAGES (S),
        ._TIMEOUT     (TO)
    ) dut (
        .io_clk        (io_clk),
        .io_rst        (io_rst),
        .io_trigIn     (io_trigIn),
        .io_fbIn       (io_fbIn),
        .io_timingOut  (io_timingOut),
        .io_fbCatchOut (io_fbCatchOut),
        .io_timeout    (io_timeout),
        .io_busy       (io_busy),
        .io_timeoutCnt (io_timeoutCnt)
    );

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // fb level sampled at edge k since reset; nothing seen before reset
    function automatic bit samp(int k);
        if (k < 0 || k >= smp.size())
            return 1'b0;
        return smp[k];
    endfunction

    function automatic void model_reset();
        smp.delete();
        sbq.delete();
        m_busy   = 1'b0;
        m_t0     = 0;
        m_timing = 0;
        m_tcnt   = 0;
    endfunction

    // A new fb level is seen S edges after it is sampled
    function automatic void model_edge(bit t, bit f);
        int  e;
        int  el;
        bit  r;
        e = smp.size();
        r = samp(e - S) && !samp(e - S - 1);
        if (!m_busy) begin
            if (t) begin
                m_busy = 1'b1;
                m_t0   = e;
            end
        end else begin
            el = e - m_t0;
            if (r) begin
                m_timing = el;
                sbq.push_back('{1'b1, el, m_tcnt});
                m_busy = 1'b0;
            end else if (el == TO) begin
                if (m_tcnt < 65535)
                    m_tcnt++;
                sbq.push_back('{1'b0, m_timing, m_tcnt});
                m_busy = 1'b0;
            end
        end
        smp.push_back(f);
    endfunction

    task automatic cyc(bit t, bit f);
        io_trigIn = t;
        io_fbIn   = f;
        @(posedge io_clk);
        model_edge(t, f);
        #1;
        chk("busy", io_busy, m_busy);
        chk("timing_out", io_timingOut, m_timing);
        chk("timeout_cnt", io_timeoutCnt, m_tcnt);
    endtask

    task automatic idle(int n, bit f);
        repeat (n) cyc(1'b0, f);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_timing"}, io_timingOut, 0);
        chk({tag, "_catch"}, io_fbCatchOut, 0);
        chk({tag, "_timeout"}, io_timeout, 0);
        chk({tag, "_busy"}, io_busy, 0);
        chk({tag, "_tcnt"}, io_timeoutCnt, 0);
    endtask

    task automatic do_reset();
        io_rst = 1'b1;
        model_reset();
        #1;
        chk_zero("async_rst");
        #1;
        io_rst = 1'b0;
    endtask

    always @(negedge io_clk) begin
        if (!io_rst && (io_fbCatchOut || io_timeout || sbq.size() > 0)) begin
            checks++;
            if (io_fbCatchOut && io_timeout) begin
                errors++;
                $display("FAIL sb_both: catch=1 timeout=1, want one at %0t",
                         $time);
            end else if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_spurious: catch=%0b timeout=%0b, want none at %0t",
                         io_fbCatchOut, io_timeout, $time);
            end else begin
                mon_e = sbq.pop_front();
                if (io_fbCatchOut != mon_e.is_catch ||
                    io_timeout != !mon_e.is_catch ||
                    io_timingOut != W'(mon_e.timing) ||
                    io_timeoutCnt != 16'(mon_e.tcnt)) begin
                    errors++;
                    $display("FAIL sb_strobe: got catch=%0b timeout=%0b timing=%0d tcnt=%0d, want catch=%0b timeout=%0b timing=%0d tcnt=%0d at %0t",
                             io_fbCatchOut, io_timeout, io_timingOut,
                             io_timeoutCnt, mon_e.is_catch,
                             !mon_e.is_catch, mon_e.timing,
                             mon_e.tcnt, $time);
                end
            end
        end
    end

    initial begin
        bit fbv;
        model_reset();
        io_rst = 1'b1;
        repeat (2) @(posedge io_clk);
        #1;
        chk_zero("reset");
        #2;
        io_rst = 1'b0;

        // capture 12 cycles after trigger
        for (int e = 0; e <= 14; e++) begin
            cyc(e == 0, e >= 10);
            if (e == 11)
                chk("cap_busy_open", io_busy, 1);
            if (e == 12) begin
                chk("cap_catch", io_fbCatchOut, 1);
                chk("cap_value", io_timingOut, 12);
                chk("cap_busy_closed", io_busy, 0);
            end
        end
        idle(6, 1'b0);

        // timeout, previous timing held
        for (int e = 0; e <= 17; e++) begin
            cyc(e == 0, 1'b0);
            if (e == 16) begin
                chk("to_strobe", io_timeout, 1);
                chk("to_cnt", io_timeoutCnt, 1);
                chk("to_hold", io_timingOut, 12);
            end
        end
        idle(3, 1'b0);

        // rise on the last window edge beats timeout
        for (int e = 0; e <= 17; e++) begin
            cyc(e == 0, e >= 14);
            if (e == 16) begin
                chk("edge_catch", io_fbCatchOut, 1);
                chk("edge_no_to", io_timeout, 0);
                chk("edge_value", io_timingOut, 16);
                chk("edge_tcnt", io_timeoutCnt, 1);
            end
        end
        idle(6, 1'b0);

        // retrigger inside window is ignored
        for (int e = 0; e <= 14; e++) begin
            cyc(e == 0 || e == 3, e >= 10);
            if (e == 12)
                chk("retrig_value", io_timingOut, 12);
        end
        idle(6, 1'b0);

        // fb already high at trigger never captures
        idle(5, 1'b1);
        for (int e = 0; e <= 17; e++) begin
            cyc(e == 0, 1'b1);
            if (e == 16) begin
                chk("high_to", io_timeout, 1);
                chk("high_tcnt", io_timeoutCnt, 2);
                chk("high_hold", io_timingOut, 12);
            end
        end
        for (int e = 0; e <= 4; e++)
            cyc(e == 0, 1'b1);
        do_reset();
        idle(20, 1'b1);
        idle(3, 1'b0);

        fbv = 1'b0;
        repeat (2500) begin
            if ($urandom_range(0, 5) == 0)
                fbv = ~fbv;
            cyc($urandom_range(0, 5) == 0, fbv);
            if ($urandom_range(0, 299) == 0)
                do_reset();
        end
        idle(25, 1'b0);
        chk("sb_drain", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
